// File: rtl/puf_frame_ctrl.sv
// ---------------------------------------------------------------------------
// puf_frame_ctrl
//
// Challenge/response framing controller sitting between a UART byte layer
// and an arbiter PUF. A challenge of CHAL_BYTES bytes is assembled from the
// receive strobe (first byte lands in the MSB). The PUF is then preset with
// its race signal low for PRESET_CYCLES, fired with the signal high for
// EVAL_CYCLES, and its response is captured. The response is streamed back
// LSB byte first over a valid/ready handshake.
//
// Ports
//   clk            system clock
//   rst            asynchronous, active-high reset
//   rx_valid       single-cycle strobe qualifying rx_data
//   rx_data        received byte
//   tx_valid       outgoing byte available
//   tx_data        outgoing byte
//   tx_ready       byte accepted when tx_valid && tx_ready
//   puf_challenge  challenge presented to the PUF (held until the next
//                  complete challenge has been received)
//   puf_signal     PUF race launch signal (high only while firing)
//   puf_response   PUF response word
//   busy           high in every state other than IDLE and RECV
//   frame_done     one-cycle pulse after the last response byte is accepted
//   frame_err      one-cycle pulse after an inter-byte timeout
//   overrun        sticky flag: a byte arrived while busy (cleared by rst)
// ---------------------------------------------------------------------------
module puf_frame_ctrl #(
   parameter int CHAL_BYTES     = 16,
   parameter int RESP_BYTES     = 16,
   parameter int PRESET_CYCLES  = 1024,
   parameter int EVAL_CYCLES    = 1024,
   parameter int TIMEOUT_CYCLES = 100000
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    rx_valid,
   input  logic [7:0]              rx_data,
   output logic                    tx_valid,
   output logic [7:0]              tx_data,
   input  logic                    tx_ready,
   output logic [8*CHAL_BYTES-1:0] puf_challenge,
   output logic                    puf_signal,
   input  logic [8*RESP_BYTES-1:0] puf_response,
   output logic                    busy,
   output logic                    frame_done,
   output logic                    frame_err,
   output logic                    overrun
);

   localparam int CHAL_W  = 8 * CHAL_BYTES;
   localparam int RESP_W  = 8 * RESP_BYTES;
   localparam int CYC_MAX = (PRESET_CYCLES > EVAL_CYCLES) ? PRESET_CYCLES : EVAL_CYCLES;
   localparam int CYC_W   = $clog2(CYC_MAX + 1);
   localparam int IDLE_W  = $clog2(TIMEOUT_CYCLES + 1);
   localparam int BYTE_W  = $clog2(CHAL_BYTES + 1);
   localparam int REM_W   = $clog2(RESP_BYTES + 1);

   // Terminal compare values: every counter stops at these, so none can wrap.
   localparam logic [CYC_W-1:0]  PRESET_LAST = CYC_W'(PRESET_CYCLES - 1);
   localparam logic [CYC_W-1:0]  EVAL_LAST   = CYC_W'(EVAL_CYCLES - 1);
   localparam logic [IDLE_W-1:0] IDLE_LAST   = IDLE_W'(TIMEOUT_CYCLES - 1);
   localparam logic [BYTE_W-1:0] BYTE_LAST   = BYTE_W'(CHAL_BYTES - 1);
   localparam logic [REM_W-1:0]  REM_FULL    = REM_W'(RESP_BYTES);
   localparam logic [REM_W-1:0]  REM_ONE     = REM_W'(1);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_RECV    = 3'd1,
      ST_PRESET  = 3'd2,
      ST_FIRE    = 3'd3,
      ST_CAPTURE = 3'd4,
      ST_SEND    = 3'd5
   } state_t;

   state_t              r_state;
   state_t              w_state_next;

   logic [CHAL_W-1:0]   r_shift;
   logic [CHAL_W-1:0]   r_chal;
   logic [RESP_W-1:0]   r_tx_shift;
   logic [BYTE_W-1:0]   r_byte_cnt;
   logic [IDLE_W-1:0]   r_idle_cnt;
   logic [CYC_W-1:0]    r_cyc_cnt;
   logic [REM_W-1:0]    r_rem_cnt;
   logic                r_frame_done;
   logic                r_frame_err;
   logic                r_overrun;

   logic [CHAL_W-1:0]   w_shift_next;
   logic                w_busy;
   logic                w_shift_en;
   logic                w_load_chal;
   logic                w_byte_clr;
   logic                w_byte_inc;
   logic                w_idle_clr;
   logic                w_idle_inc;
   logic                w_cyc_clr;
   logic                w_cyc_inc;
   logic                w_capture;
   logic                w_rem_load;
   logic                w_tx_adv;
   logic                w_done;
   logic                w_err;

   // New byte enters at the bottom so the first byte of a frame ends up in
   // the MSB. Written as a shift so it also holds for a one-byte challenge.
   assign w_shift_next = (r_shift << 8) | CHAL_W'(rx_data);

   assign w_busy = !((r_state == ST_IDLE) || (r_state == ST_RECV));

   // ------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // ------------------------------------------------------------------
   // Next-state and control strobes
   // ------------------------------------------------------------------
   always_comb begin
      w_state_next = r_state;
      w_shift_en   = 1'b0;
      w_load_chal  = 1'b0;
      w_byte_clr   = 1'b0;
      w_byte_inc   = 1'b0;
      w_idle_clr   = 1'b0;
      w_idle_inc   = 1'b0;
      w_cyc_clr    = 1'b0;
      w_cyc_inc    = 1'b0;
      w_capture    = 1'b0;
      w_rem_load   = 1'b0;
      w_tx_adv     = 1'b0;
      w_done       = 1'b0;
      w_err        = 1'b0;

      case (r_state)
         // IDLE and RECV share the byte path: the byte count is 0 in IDLE,
         // so a one-byte challenge completes directly from IDLE.
         ST_IDLE, ST_RECV: begin
            if (rx_valid) begin
               // A byte in the expiry cycle wins over the timeout.
               w_shift_en = 1'b1;
               w_idle_clr = 1'b1;
               if (r_byte_cnt == BYTE_LAST) begin
                  w_load_chal  = 1'b1;
                  w_byte_clr   = 1'b1;
                  w_cyc_clr    = 1'b1;
                  w_state_next = ST_PRESET;
               end else begin
                  w_byte_inc   = 1'b1;
                  w_state_next = ST_RECV;
               end
            end else if (r_state == ST_RECV) begin
               if (r_idle_cnt == IDLE_LAST) begin
                  w_err        = 1'b1;
                  w_byte_clr   = 1'b1;
                  w_idle_clr   = 1'b1;
                  w_state_next = ST_IDLE;
               end else begin
                  w_idle_inc = 1'b1;
               end
            end
         end

         ST_PRESET: begin
            if (r_cyc_cnt == PRESET_LAST) begin
               w_cyc_clr    = 1'b1;
               w_state_next = ST_FIRE;
            end else begin
               w_cyc_inc = 1'b1;
            end
         end

         // The response is sampled on the edge that ends the race window.
         ST_FIRE: begin
            if (r_cyc_cnt == EVAL_LAST) begin
               w_cyc_clr    = 1'b1;
               w_capture    = 1'b1;
               w_state_next = ST_CAPTURE;
            end else begin
               w_cyc_inc = 1'b1;
            end
         end

         ST_CAPTURE: begin
            w_rem_load   = 1'b1;
            w_state_next = ST_SEND;
         end

         ST_SEND: begin
            if (tx_ready) begin
               w_tx_adv = 1'b1;
               if (r_rem_cnt == REM_ONE) begin
                  w_done       = 1'b1;
                  w_state_next = ST_IDLE;
               end
            end
         end

         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Counters
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_byte_cnt <= '0;
         r_idle_cnt <= '0;
         r_cyc_cnt  <= '0;
         r_rem_cnt  <= '0;
      end else begin
         if (w_byte_clr) begin
            r_byte_cnt <= '0;
         end else if (w_byte_inc) begin
            r_byte_cnt <= r_byte_cnt + BYTE_W'(1);
         end

         if (w_idle_clr) begin
            r_idle_cnt <= '0;
         end else if (w_idle_inc) begin
            r_idle_cnt <= r_idle_cnt + IDLE_W'(1);
         end

         if (w_cyc_clr) begin
            r_cyc_cnt <= '0;
         end else if (w_cyc_inc) begin
            r_cyc_cnt <= r_cyc_cnt + CYC_W'(1);
         end

         if (w_rem_load) begin
            r_rem_cnt <= REM_FULL;
         end else if (w_tx_adv) begin
            r_rem_cnt <= r_rem_cnt - REM_ONE;
         end
      end
   end

   // ------------------------------------------------------------------
   // Challenge / response datapath and status flags
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_shift      <= '0;
         r_chal       <= '0;
         r_tx_shift   <= '0;
         r_frame_done <= 1'b0;
         r_frame_err  <= 1'b0;
         r_overrun    <= 1'b0;
      end else begin
         // A timed-out partial frame is discarded.
         if (w_err) begin
            r_shift <= '0;
         end else if (w_shift_en) begin
            r_shift <= w_shift_next;
         end

         if (w_load_chal) begin
            r_chal <= w_shift_next;
         end

         if (w_capture) begin
            r_tx_shift <= puf_response;
         end else if (w_tx_adv) begin
            r_tx_shift <= r_tx_shift >> 8;
         end

         r_frame_done <= w_done;
         r_frame_err  <= w_err;

         // Bytes arriving while busy are dropped; only the flag records them.
         if (rx_valid && w_busy) begin
            r_overrun <= 1'b1;
         end
      end
   end

   // Outputs decode registered state, so they clear as soon as rst asserts.
   assign tx_valid      = (r_state == ST_SEND);
   assign tx_data       = r_tx_shift[7:0];
   assign puf_challenge = r_chal;
   assign puf_signal    = (r_state == ST_FIRE);
   assign busy          = w_busy;
   assign frame_done    = r_frame_done;
   assign frame_err     = r_frame_err;
   assign overrun       = r_overrun;

endmodule

// File: tb/tb_puf_frame_ctrl.sv
// ---------------------------------------------------------------------------
// tb_puf_frame_ctrl
//
// Bench for puf_frame_ctrl. Two instances share the clock and reset:
//   u_a : CHAL=RESP=4 bytes, PRESET=EVAL=8, TIMEOUT=20
//   u_b : CHAL=RESP=1 byte,  PRESET=EVAL=1, TIMEOUT=20
// The variable sel steers stimulus to one instance and selects which
// instance's outputs are observed. Inputs change and outputs are sampled
// on the falling clock edge. Expectations come from the frame-level rules:
// challenge = received bytes concatenated MSB first, race signal rises at
// cycle P+1 for E cycles, first byte offered at cycle P+E+2, response bytes
// LSB first, frame_done one cycle after the last accept, frame_err one cycle
// after TIMEOUT idle cycles.
// ---------------------------------------------------------------------------
module tb_puf_frame_ctrl;

   localparam int T = 20;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        rx_valid;
   logic [7:0]  rx_data;
   logic        tx_ready;
   logic [31:0] resp;
   bit          sel;

   logic        rx_valid_a, rx_valid_b;
   logic        tx_valid_a, tx_valid_b;
   logic [7:0]  tx_data_a, tx_data_b;
   logic [31:0] chal_a;
   logic [7:0]  chal_b;
   logic        sig_a, sig_b, busy_a, busy_b;
   logic        done_a, done_b, err_a, err_b, ovr_a, ovr_b;

   assign rx_valid_a = rx_valid & ~sel;
   assign rx_valid_b = rx_valid & sel;

   puf_frame_ctrl #(
      .CHAL_BYTES(4), .RESP_BYTES(4), .PRESET_CYCLES(8), .EVAL_CYCLES(8), .TIMEOUT_CYCLES(T)
   ) u_a (
      .clk(clk), .rst(rst), .rx_valid(rx_valid_a), .rx_data(rx_data),
      .tx_valid(tx_valid_a), .tx_data(tx_data_a), .tx_ready(tx_ready),
      .puf_challenge(chal_a), .puf_signal(sig_a), .puf_response(resp),
      .busy(busy_a), .frame_done(done_a), .frame_err(err_a), .overrun(ovr_a)
   );

   puf_frame_ctrl #(
      .CHAL_BYTES(1), .RESP_BYTES(1), .PRESET_CYCLES(1), .EVAL_CYCLES(1), .TIMEOUT_CYCLES(T)
   ) u_b (
      .clk(clk), .rst(rst), .rx_valid(rx_valid_b), .rx_data(rx_data),
      .tx_valid(tx_valid_b), .tx_data(tx_data_b), .tx_ready(tx_ready),
      .puf_challenge(chal_b), .puf_signal(sig_b), .puf_response(resp[7:0]),
      .busy(busy_b), .frame_done(done_b), .frame_err(err_b), .overrun(ovr_b)
   );

   logic        tx_valid_m, sig_m, busy_m, done_m, err_m, ovr_m;
   logic [7:0]  tx_data_m;
   logic [31:0] ch_m;

   assign tx_valid_m = sel ? tx_valid_b : tx_valid_a;
   assign tx_data_m  = sel ? tx_data_b  : tx_data_a;
   assign ch_m       = sel ? {24'h0, chal_b} : chal_a;
   assign sig_m      = sel ? sig_b  : sig_a;
   assign busy_m     = sel ? busy_b : busy_a;
   assign done_m     = sel ? done_b : done_a;
   assign err_m      = sel ? err_b  : err_a;
   assign ovr_m      = sel ? ovr_b  : ovr_a;

   int          n_chk = 0;
   int          n_fail = 0;
   bit          exp_ovr [2];
   logic [31:0] last_chal [2];

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h (t=%0t sel=%0d)", tag, got, exp, $time, sel);
      end
   endtask

   // mode bit0: inject a byte during FIRE; bit1: 5-cycle backpressure per
   // byte; bit2: tx_ready always high. abort_n>0: reset after abort_n accepts.
   task automatic run_frame(input bit use_fix, input logic [31:0] fchal,
                            input logic [31:0] fresp, input int mode, input int abort_n);
      int          c_bytes, r_bytes, p_cyc, e_cyc, gap;
      int          first_sig, sig_cnt, first_tx, done_cyc, last_acc, n_acc, stall, err_cnt;
      logic [31:0] chal_exp;
      logic [7:0]  b, prev_data;
      bit          prev_stall, rdy;
      logic [7:0]  got_q [$];

      c_bytes  = sel ? 1 : 4;
      r_bytes  = c_bytes;
      p_cyc    = sel ? 1 : 8;
      e_cyc    = p_cyc;
      chal_exp = '0;
      resp     = use_fix ? fresp : $urandom;

      for (int i = 0; i < c_bytes; i++) begin
         if (i == 0) begin
            gap = 0;
         end else begin
            case ($urandom_range(0, 2))
               0:       gap = 0;
               1:       gap = T - 1;
               default: gap = $urandom_range(0, T - 1);
            endcase
         end
         repeat (gap) @(negedge clk);
         b        = use_fix ? fchal[8*(c_bytes-1-i) +: 8] : 8'($urandom);
         rx_data  = b;
         rx_valid = 1'b1;
         chal_exp = (chal_exp << 8) | {24'h0, b};
         @(negedge clk);
         rx_valid = 1'b0;
      end
      check_eq("challenge", ch_m, chal_exp);
      check_eq("busy_start", busy_m, 1);
      last_chal[sel] = chal_exp;

      first_sig = 0; sig_cnt = 0; first_tx = 0; done_cyc = 0;
      last_acc = 0; n_acc = 0; stall = 0; err_cnt = 0;
      prev_stall = 1'b0; prev_data = '0;
      for (int k = 1; k <= p_cyc + e_cyc + 8*r_bytes + 10 && done_cyc == 0; k++) begin
         if (abort_n != 0 && n_acc == abort_n) begin
            check_eq("pre_rst_valid", tx_valid_m, 1);
            #1 rst = 1'b1;
            #1;
            check_eq("rst_tx_valid", tx_valid_m, 0);
            check_eq("rst_tx_data", tx_data_m, 0);
            check_eq("rst_busy", busy_m, 0);
            check_eq("rst_chal", ch_m, 0);
            check_eq("rst_flags", {sig_m, done_m, err_m, ovr_m}, 0);
            exp_ovr[0] = 1'b0; exp_ovr[1] = 1'b0;
            last_chal[0] = '0; last_chal[1] = '0;
            rx_valid = 1'b0; tx_ready = 1'b0;
            @(negedge clk);
            rst = 1'b0;
            return;
         end
         if (sig_m) begin
            if (first_sig == 0) first_sig = k;
            sig_cnt++;
         end
         if (err_m) err_cnt++;
         if (done_m) done_cyc = k;
         if (prev_stall) begin
            check_eq("tx_valid_hold", tx_valid_m, 1);
            check_eq("tx_data_hold", tx_data_m, prev_data);
         end
         if (tx_valid_m && first_tx == 0) first_tx = k;
         if (mode[2])      rdy = 1'b1;
         else if (mode[1]) rdy = (stall >= 5);
         else              rdy = 1'($urandom_range(0, 1));
         tx_ready = rdy;
         if (tx_valid_m) begin
            if (rdy) begin
               got_q.push_back(tx_data_m);
               n_acc++;
               last_acc = k;
               stall = 0;
            end else begin
               stall++;
            end
         end
         prev_stall = tx_valid_m && !rdy;
         prev_data  = tx_data_m;
         rx_valid   = (mode[0] && k == p_cyc + 1);
         if (rx_valid) begin
            rx_data      = 8'($urandom);
            exp_ovr[sel] = 1'b1;
         end
         @(negedge clk);
      end
      tx_ready = 1'b0;
      rx_valid = 1'b0;

      check_eq("done_seen", done_cyc != 0, 1);
      check_eq("sig_rise", first_sig, p_cyc + 1);
      check_eq("sig_len", sig_cnt, e_cyc);
      check_eq("tx_first", first_tx, p_cyc + e_cyc + 2);
      check_eq("n_bytes", got_q.size(), r_bytes);
      for (int i = 0; i < got_q.size() && i < r_bytes; i++)
         check_eq("tx_byte", got_q[i], resp[8*i +: 8]);
      check_eq("done_timing", done_cyc, last_acc + 1);
      check_eq("done_pulse", done_m, 0);
      check_eq("busy_after", busy_m, 0);
      check_eq("err_none", err_cnt, 0);
      check_eq("overrun", ovr_m, exp_ovr[sel]);
      check_eq("chal_hold", ch_m, chal_exp);
   endtask

   task automatic run_timeout(input int nbytes);
      int err_cyc, err_cnt, busy_cnt;
      err_cyc = 0; err_cnt = 0; busy_cnt = 0;
      for (int i = 0; i < nbytes; i++) begin
         if (i != 0) repeat ($urandom_range(0, T - 1)) @(negedge clk);
         rx_data  = 8'($urandom);
         rx_valid = 1'b1;
         @(negedge clk);
         rx_valid = 1'b0;
      end
      for (int k = 1; k <= T + 6; k++) begin
         if (err_m) begin
            err_cnt++;
            if (err_cyc == 0) err_cyc = k;
         end
         if (busy_m) busy_cnt++;
         @(negedge clk);
      end
      check_eq("err_count", err_cnt, 1);
      check_eq("err_cycle", err_cyc, T + 1);
      check_eq("busy_timeout", busy_cnt, 0);
      check_eq("chal_kept", ch_m, last_chal[sel]);
   endtask

   initial begin
      rst = 1'b1; rx_valid = 1'b0; rx_data = '0; tx_ready = 1'b0; resp = '0; sel = 1'b0;
      exp_ovr[0] = 1'b0; exp_ovr[1] = 1'b0;
      last_chal[0] = '0; last_chal[1] = '0;
      #12;
      check_eq("reset_a", {tx_valid_a, tx_data_a, sig_a, busy_a, done_a, err_a, ovr_a}, 0);
      check_eq("reset_chal_a", chal_a, 0);
      check_eq("reset_b", {tx_valid_b, tx_data_b, chal_b, sig_b, busy_b, done_b, err_b, ovr_b}, 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      sel = 1'b0;
      run_frame(1'b1, 32'h11223344, 32'hA1B2C3D4, 4, 0);
      run_frame(1'b0, '0, '0, 2, 0);
      for (int n = 0; n < 4; n++) run_frame(1'b0, '0, '0, 0, 0);
      run_timeout(2);
      run_frame(1'b0, '0, '0, 0, 0);
      run_timeout(3);
      run_frame(1'b0, '0, '0, 1, 0);
      run_frame(1'b0, '0, '0, 0, 0);
      run_frame(1'b0, '0, '0, 4, 2);
      run_frame(1'b0, '0, '0, 0, 0);

      sel = 1'b1;
      @(negedge clk);
      run_frame(1'b1, 32'h0000005A, '0, 4, 0);
      run_frame(1'b0, '0, '0, 0, 0);
      run_frame(1'b0, '0, '0, 1, 0);
      run_frame(1'b0, '0, '0, 2, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired at t=%0t", $time);
      $fatal(1);
   end

endmodule

// File: doc/puf_frame_ctrl.md
# puf_frame_ctrl

Parametrised challenge/response controller between the UART byte layer (UART_RX/UART_TX) and an arbiter PUF. It assembles a CHAL_BYTES challenge from received bytes, then runs a two-phase PUF evaluation: preset with signal low, then fire with signal high. It captures the RESP_BYTES response and streams it back byte-by-byte over a valid/ready handshake. This generation adds configurable widths and settle times, an inter-byte timeout, overrun flagging and a reset.

## Interface
Parameters:
- CHAL_BYTES, 16: challenge length in bytes (≥1); CHAL_W = 8*CHAL_BYTES.
- RESP_BYTES, 16: response length in bytes (≥1); RESP_W = 8*RESP_BYTES.
- PRESET_CYCLES, 1024: cycles with puf_signal=0 before firing (≥1).
- EVAL_CYCLES, 1024: cycles with puf_signal=1 before capture (≥1).
- TIMEOUT_CYCLES, 100000: max idle cycles between challenge bytes (≥1).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- rx_valid  in  1  single-cycle strobe; rx_data is valid this cycle.
- rx_data  in  8  received byte.
- tx_valid  out  1  outgoing byte available.
- tx_data  out  8  outgoing byte.
- tx_ready  in  1  transmitter accepts the byte when tx_valid && tx_ready.
- puf_challenge  out  CHAL_W  challenge applied to the PUF.
- puf_signal  out  1  PUF race launch signal.
- puf_response  in  RESP_W  PUF response.
- busy  out  1  high in every state except IDLE and RECV.
- frame_done  out  1  one-cycle pulse when the last response byte is accepted.
- frame_err  out  1  one-cycle pulse on inter-byte timeout.
- overrun  out  1  sticky; set when a byte arrives while busy; cleared only by rst.

## Operation
- States: IDLE, RECV, PRESET, FIRE, CAPTURE, SEND.
- IDLE: on rx_valid, shift the byte in, set byte count to 1, go to RECV. If CHAL_BYTES=1, go straight to PRESET.
- RECV: each rx_valid does shift_reg <= {shift_reg[CHAL_W-9:0], rx_data} (first byte ends up MSB) and increments the byte count.
  - On byte CHAL_BYTES: load puf_challenge from the completed shift value in the same edge, clear the cycle counter, go to PRESET.
- RECV timeout: the idle counter resets on every byte. At TIMEOUT_CYCLES consecutive cycles without a byte: discard the partial frame, clear the count, pulse frame_err, go to IDLE.
- PRESET: puf_signal=0 for exactly PRESET_CYCLES cycles, then FIRE.
- FIRE: puf_signal=1 for exactly EVAL_CYCLES cycles, then CAPTURE.
- CAPTURE: one cycle. Register puf_response into the tx shift register, drop puf_signal to 0, set the remaining count to RESP_BYTES, go to SEND.
- SEND: tx_valid=1, tx_data = tx_shift[7:0] (response sent LSB byte first).
  - On handshake: shift right by 8, decrement the remaining count.
  - After the last handshake: tx_valid=0, pulse frame_done, go to IDLE.
- rx_valid in PRESET, FIRE, CAPTURE or SEND: byte dropped, overrun set, state unaffected.
- puf_challenge holds its value from load until the next frame completes reception.
- Counters are sized by $clog2 of their maximum plus 1. No wrap-around is permitted; each counter saturates at its terminal compare.

## Timing
- Reset values: tx_valid=0, tx_data=0, puf_challenge=0, puf_signal=0, busy=0, frame_done=0, frame_err=0, overrun=0. State=IDLE and all counters 0.
- Reset mid-operation aborts immediately to IDLE, including mid-SEND: tx_valid drops asynchronously and no partial frame is resumed.
- Latency from the edge that accepts the last challenge byte:
  - PRESET occupies cycles 1..PRESET_CYCLES.
  - puf_signal rises at cycle PRESET_CYCLES+1 and stays high EVAL_CYCLES cycles.
  - Capture happens on the edge ending FIRE.
  - tx_valid rises the cycle after CAPTURE.
- SEND handshake:
  - tx_data is stable while tx_valid && !tx_ready.
  - With tx_ready held high, one byte transfers per cycle.
  - tx_valid never deasserts before its byte has been accepted.
- In RECV, a byte and timeout expiry in the same cycle: the byte wins and no error is raised.
- frame_done and frame_err are never asserted in the same cycle.

## Test plan
- Nominal (CHAL_BYTES=RESP_BYTES=4, PRESET=EVAL=8): send 0x11,0x22,0x33,0x44 with gaps.
  - puf_challenge=0x11223344 after the 4th byte.
  - puf_signal low 8 cycles, then high 8 cycles.
  - With puf_response=0xA1B2C3D4, tx bytes are D4,C3,B2,A1, then a frame_done pulse.
- Backpressure: hold tx_ready low for 5 cycles per byte. tx_data holds each byte stable, ordering is unchanged, and frame_done comes after the 4th accept.
- Timeout (TIMEOUT=20): send 2 bytes, then idle 20 cycles.
  - frame_err pulses once, state returns to IDLE, and busy stays 0.
  - A following full 4-byte frame yields the correct challenge.
- Overrun: inject rx_valid during FIRE. overrun=1 and stays set, the challenge and response sequence are unaffected, and the byte is not counted toward the next frame.
- Reset mid-SEND: assert rst after 2 bytes have been sent. All outputs return to reset values asynchronously, and the next frame runs normally from byte 1.
- Edge parameters CHAL_BYTES=1, RESP_BYTES=1, PRESET=EVAL=1: a single byte 0x5A gives puf_challenge=0x5A, a 1-cycle puf_signal pulse, and one tx byte equal to puf_response.
